// File: rtl/regfile_writeback.sv
// Commit-side writer for the physical register file.
//
// Up to three retiring results per cycle are compacted (rd=0 lanes dropped) into an in-order
// circular FIFO. When the register file can take writes, up to three of the oldest entries are
// moved into registered write-request ports, oldest on port a. Inside one drained group only the
// youngest write to a given register keeps RegWrite. A per-register pending mask reports every
// write that is still buffered or sitting in the output stage.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   commit_valid  per-lane valid, lane 0 oldest
//   commit_rd     per-lane destination physical register
//   commit_data   per-lane result
//   commit_ready  whole group accepted this cycle when high
//   drain_en      register file accepts writes this cycle
//   wr_req_a/b/c  registered write requests, a is oldest
//   pending_mask  bit r set while any write to register r is in flight

package regfile_writeback_pkg;

  typedef struct packed {
    logic        RegWrite;
    logic [6:0]  rd;
    logic [6:0]  rs1;
    logic [6:0]  rs2;
    logic [31:0] wr_data;
  } regReqStruct;

endpackage

module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_PREGS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            commit_valid,
  input  logic [2:0][6:0]       commit_rd,
  input  logic [2:0][31:0]      commit_data,
  output logic                  commit_ready,
  input  logic                  drain_en,
  output regReqStruct           wr_req_a,
  output regReqStruct           wr_req_b,
  output regReqStruct           wr_req_c,
  output logic [NUM_PREGS-1:0]  pending_mask
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  // FIFO storage; no reset needed since validity comes from head/occ.
  logic [6:0]      mem_rd_q   [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;

  regReqStruct     out_q [3];
  regReqStruct     out_d [3];

  logic            space_ok;
  logic            enq_fire;
  logic [1:0]      n_enq;
  logic [2:0]      enq_we;
  logic [6:0]      enq_rd   [3];
  logic [31:0]     enq_data [3];
  logic [1:0]      n_drain;

  logic [PtrW-1:0] slot_rel   [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  // Free space is judged on current occupancy only; a same-cycle drain does not help.
  assign space_ok     = (OccW'(DEPTH) - occ_q) >= OccW'(3);
  assign commit_ready = space_ok & ~reset;
  assign enq_fire     = space_ok & (|commit_valid);

  // Compact the stored lanes in lane order into consecutive tail slots.
  always_comb begin
    n_enq  = 2'd0;
    enq_we = '0;
    for (int k = 0; k < 3; k++) begin
      enq_rd[k]   = '0;
      enq_data[k] = '0;
    end
    for (int l = 0; l < 3; l++) begin
      if (enq_fire && commit_valid[l] && (commit_rd[l] != 7'd0)) begin
        enq_we[n_enq]   = 1'b1;
        enq_rd[n_enq]   = commit_rd[l];
        enq_data[n_enq] = commit_data[l];
        n_enq           = n_enq + 2'd1;
      end
    end
  end

  // Drain group selection and collision suppression.
  always_comb begin
    if (!drain_en) begin
      n_drain = 2'd0;
    end else if (occ_q >= OccW'(3)) begin
      n_drain = 2'd3;
    end else begin
      n_drain = occ_q[1:0];
    end

    for (int i = 0; i < 3; i++) begin
      out_d[i] = '0;
      if (2'(i) < n_drain) begin
        out_d[i].RegWrite = 1'b1;
        out_d[i].rd       = mem_rd_q[head_q + PtrW'(i)];
        out_d[i].wr_data  = mem_data_q[head_q + PtrW'(i)];
      end
    end

    // An older write in the group is dead if a younger one targets the same register.
    for (int i = 0; i < 2; i++) begin
      for (int j = i + 1; j < 3; j++) begin
        if ((2'(j) < n_drain) && (out_d[i].rd == out_d[j].rd)) begin
          out_d[i].RegWrite = 1'b0;
        end
      end
    end
  end

  always_comb begin
    head_d = head_q + PtrW'(n_drain);
    tail_d = tail_q + PtrW'(n_enq);
    occ_d  = occ_q + OccW'(n_enq) - OccW'(n_drain);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      for (int i = 0; i < 3; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (enq_we[k]) begin
        mem_rd_q[tail_q + PtrW'(k)]   <= enq_rd[k];
        mem_data_q[tail_q + PtrW'(k)] <= enq_data[k];
      end
    end
  end

  assign wr_req_a = out_q[0];
  assign wr_req_b = out_q[1];
  assign wr_req_c = out_q[2];

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      slot_rel[s]   = PtrW'(s) - head_q;
      slot_valid[s] = OccW'(slot_rel[s]) < occ_q;
    end
  end

  // Register 0 is never written, so bit 0 stays clear (loops start at 1).
  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NUM_PREGS; r++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (slot_valid[s] && (mem_rd_q[s] == 7'(r))) begin
          pending_mask[r] = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (out_q[i].RegWrite && (out_q[i].rd == 7'(r))) begin
          pending_mask[r] = 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  occ_bound_a : assert property (@(posedge clk) disable iff (reset)
    occ_q <= OccW'(DEPTH));

  no_rd0_write_a : assert property (@(posedge clk) disable iff (reset)
    !((out_q[0].RegWrite && (out_q[0].rd == 7'd0)) ||
      (out_q[1].RegWrite && (out_q[1].rd == 7'd0)) ||
      (out_q[2].RegWrite && (out_q[2].rd == 7'd0))));

  no_dup_rd_a : assert property (@(posedge clk) disable iff (reset)
    !((out_q[0].RegWrite && out_q[1].RegWrite && (out_q[0].rd == out_q[1].rd)) ||
      (out_q[0].RegWrite && out_q[2].RegWrite && (out_q[0].rd == out_q[2].rd)) ||
      (out_q[1].RegWrite && out_q[2].RegWrite && (out_q[1].rd == out_q[2].rd))));
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: queue-level reference model with a per-cycle
// compare process, plus directed scenarios with hand-computed literal expectations.

module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       commit_valid = '0;
  logic [2:0][6:0]  commit_rd = '0;
  logic [2:0][31:0] commit_data = '0;
  logic             commit_ready;
  logic             drain_en = 1'b0;
  regReqStruct      wr_req_a, wr_req_b, wr_req_c;
  logic [63:0]      pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback #(.DEPTH(DEPTH), .NUM_PREGS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .drain_en     (drain_en),
    .wr_req_a     (wr_req_a),
    .wr_req_b     (wr_req_b),
    .wr_req_c     (wr_req_c),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of {rd,data} plus the output stage -------------
  typedef struct {
    logic [6:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  ex_we = '0;
  logic [6:0]  ex_rd   [3];
  logic [31:0] ex_data [3];

  always @(posedge clk or posedge reset) begin : model
    int   nd;
    bit   rdy;
    ent_t g [3];
    ent_t e;
    if (reset) begin
      mq.delete();
      ex_we = '0;
    end else begin
      rdy   = (DEPTH - mq.size()) >= 3;
      ex_we = '0;
      if (drain_en) begin
        nd = (mq.size() < 3) ? mq.size() : 3;
        for (int i = 0; i < nd; i++) g[i] = mq.pop_front();
        for (int i = 0; i < nd; i++) begin
          ex_we[i]   = 1'b1;
          ex_rd[i]   = g[i].rd;
          ex_data[i] = g[i].data;
          for (int j = i + 1; j < nd; j++) if (g[j].rd == g[i].rd) ex_we[i] = 1'b0;
        end
      end
      if (rdy) begin
        for (int l = 0; l < 3; l++) begin
          if (commit_valid[l] && commit_rd[l] != 7'd0) begin
            e.rd   = commit_rd[l];
            e.data = commit_data[l];
            mq.push_back(e);
          end
        end
      end
    end
  end

  function automatic logic [63:0] exp_mask();
    logic [63:0] m = '0;
    foreach (mq[i]) m[mq[i].rd[5:0]] = 1'b1;
    for (int i = 0; i < 3; i++) if (ex_we[i]) m[ex_rd[i][5:0]] = 1'b1;
    return m;
  endfunction

  task automatic cmp_port(input string name, input regReqStruct p, input int i);
    chk({name, ".RegWrite"}, p.RegWrite, ex_we[i]);
    if (ex_we[i]) begin
      chk({name, ".rd"}, p.rd, ex_rd[i]);
      chk({name, ".wr_data"}, p.wr_data, ex_data[i]);
    end
    chk({name, ".rs"}, {p.rs1, p.rs2}, 0);
  endtask

  always @(negedge clk) begin
    chk("commit_ready", commit_ready, (!reset && (DEPTH - mq.size()) >= 3));
    cmp_port("wr_req_a", wr_req_a, 0);
    cmp_port("wr_req_b", wr_req_b, 1);
    cmp_port("wr_req_c", wr_req_c, 2);
    chk("pending_mask", pending_mask, exp_mask());
  end

  // ---------------- register file fed by the DUT, plus a write log --------------------------
  logic [31:0] rf [128];
  logic [31:0] wlog[$];

  always @(posedge clk) begin
    if (wr_req_a.RegWrite) begin rf[wr_req_a.rd] = wr_req_a.wr_data; wlog.push_back(wr_req_a.wr_data); end
    if (wr_req_b.RegWrite) begin rf[wr_req_b.rd] = wr_req_b.wr_data; wlog.push_back(wr_req_b.wr_data); end
    if (wr_req_c.RegWrite) begin rf[wr_req_c.rd] = wr_req_c.wr_data; wlog.push_back(wr_req_c.wr_data); end
  end

  // ---------------- stimulus helpers --------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [2:0] v, input logic [6:0] r0, r1, r2,
                           input logic [31:0] d0, d1, d2);
    commit_valid   = v;
    commit_rd[0]   = r0;
    commit_rd[1]   = r1;
    commit_rd[2]   = r2;
    commit_data[0] = d0;
    commit_data[1] = d1;
    commit_data[2] = d2;
  endtask

  // Present a group and hold it until an edge at which commit_ready was high.
  task automatic commit_group(input logic [2:0] v, input logic [6:0] r0, r1, r2,
                              input logic [31:0] d0, d1, d2);
    int guard = 0;
    set_lanes(v, r0, r1, r2, d0, d1, d2);
    while (!commit_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard == 20) chk("commit_group timeout", 0, 1);
    tick();
    commit_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    chk("reset commit_ready", commit_ready, 0);
    chk("reset pending_mask", pending_mask, 0);
    chk("reset wr_req_a", wr_req_a, 0);
    reset = 1'b0;
    #1;
    chk("post-reset commit_ready", commit_ready, 1);

    // Basic three-lane group.
    drain_en = 1'b1;
    commit_group(3'b111, 7'd5, 7'd6, 7'd7, 32'h11, 32'h22, 32'h33);
    chk("t1 pending after accept", pending_mask[7:5], 3'b111);
    tick();
    chk("t1 wr_req_a", wr_req_a, {1'b1, 7'd5, 7'd0, 7'd0, 32'h11});
    chk("t1 wr_req_b", wr_req_b, {1'b1, 7'd6, 7'd0, 7'd0, 32'h22});
    chk("t1 wr_req_c", wr_req_c, {1'b1, 7'd7, 7'd0, 7'd0, 32'h33});
    chk("t1 pending in output stage", pending_mask[7:5], 3'b111);
    tick();
    chk("t1 pending cleared", pending_mask[7:5], 3'b000);
    chk("t1 rf[6]", rf[6], 32'h22);

    // rd=0 lane dropped, invalid lane ignored.
    commit_group(3'b011, 7'd0, 7'd9, 7'd0, 32'hAA, 32'hBB, 32'h0);
    chk("t2 pending[9]", pending_mask[9], 1);
    chk("t2 pending[0]", pending_mask[0], 0);
    tick();
    chk("t2 wr_req_a", wr_req_a, {1'b1, 7'd9, 7'd0, 7'd0, 32'hBB});
    chk("t2 wr_req_b.RegWrite", wr_req_b.RegWrite, 0);
    chk("t2 wr_req_c.RegWrite", wr_req_c.RegWrite, 0);
    chk("t2 pending[0] out stage", pending_mask[0], 0);

    // Same-destination collision inside one group.
    commit_group(3'b111, 7'd12, 7'd12, 7'd12, 32'd1, 32'd2, 32'd3);
    tick();
    chk("t3 wr_req_a.RegWrite", wr_req_a.RegWrite, 0);
    chk("t3 wr_req_b.RegWrite", wr_req_b.RegWrite, 0);
    chk("t3 wr_req_c", wr_req_c, {1'b1, 7'd12, 7'd0, 7'd0, 32'd3});
    tick();
    tick();
    chk("t3 rf[12]", rf[12], 32'd3);

    // Full boundary with drain held off.
    drain_en = 1'b0;
    commit_group(3'b111, 7'd20, 7'd21, 7'd22, 32'h20, 32'h21, 32'h22);
    commit_group(3'b111, 7'd23, 7'd24, 7'd25, 32'h23, 32'h24, 32'h25);
    chk("t4 ready at occ 6", commit_ready, 0);
    set_lanes(3'b111, 7'd26, 7'd27, 7'd28, 32'h26, 32'h27, 32'h28);
    tick();
    tick();
    chk("t4 still stalled", commit_ready, 0);
    chk("t4 third group not stored", pending_mask[26], 0);
    drain_en = 1'b1;
    tick();
    chk("t4 first drained rd", wr_req_a.rd, 7'd20);
    chk("t4 ready after drain", commit_ready, 1);
    tick();
    commit_valid = '0;
    chk("t4 second drained rd", wr_req_a.rd, 7'd23);
    tick();
    chk("t4 third group a", wr_req_a.rd, 7'd26);
    chk("t4 third group c", wr_req_c, {1'b1, 7'd28, 7'd0, 7'd0, 32'h28});
    tick();

    // Full-rate streaming across pointer wrap.
    wlog.delete();
    for (int i = 0; i < 20; i++) begin
      set_lanes(3'b111, 7'(1 + (3 * i) % 63), 7'(1 + (3 * i + 1) % 63), 7'(1 + (3 * i + 2) % 63),
                32'h1000 + 32'(3 * i), 32'h1000 + 32'(3 * i + 1), 32'h1000 + 32'(3 * i + 2));
      chk("t5 ready full rate", commit_ready, 1);
      tick();
    end
    commit_valid = '0;
    tick();
    tick();
    tick();
    chk("t5 write count", wlog.size(), 60);
    for (int i = 0; i < 60 && i < wlog.size(); i++) chk("t5 write order", wlog[i], 32'h1000 + 32'(i));

    // Reset in mid-stream with occ=5 and a live output stage.
    drain_en = 1'b0;
    commit_group(3'b111, 7'd40, 7'd41, 7'd42, 32'h40, 32'h41, 32'h42);
    commit_group(3'b011, 7'd43, 7'd44, 7'd0, 32'h43, 32'h44, 32'h0);
    drain_en = 1'b1;
    commit_group(3'b111, 7'd45, 7'd46, 7'd47, 32'h45, 32'h46, 32'h47);
    chk("t6 output live before reset", wr_req_a, {1'b1, 7'd40, 7'd0, 7'd0, 32'h40});
    chk("t6 pending[47] before reset", pending_mask[47], 1);
    #2 reset = 1'b1;
    #1;
    chk("t6 pending after reset", pending_mask, 0);
    chk("t6 wr_req_a after reset", wr_req_a, 0);
    chk("t6 wr_req_c after reset", wr_req_c, 0);
    chk("t6 ready during reset", commit_ready, 0);
    wlog.delete();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t6 no stale writes", wlog.size(), 0);
    chk("t6 ready after release", commit_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
